multicycle_arithmetic_unit: RTL

MULTICYCLE_ARITHMETIC_UNIT -- requirements
Module: multicycle_arithmetic_unit

---
 rtl/multicycle_arithmetic_unit_if.sv | 27 ++
 rtl/multicycle_arithmetic_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_arithmetic_unit_if.sv
// Request/response bundle for the multicycle arithmetic unit.
// The master drives request fields; the slave returns registered results and status.
interface multicycle_arithmetic_unit_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [9:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cin;
   logic [WIDTH-1:0] aluout;
   logic             cout;
   logic             zout;
   logic             done;
   logic             busy;
   logic             err;

   modport master (
      output start, op, A, B, cin,
      input  aluout, cout, zout, done, busy, err
   );

   modport slave (
      input  start, op, A, B, cin,
      output aluout, cout, zout, done, busy, err
   );
endinterface

// File: rtl/multicycle_arithmetic_unit.sv
// One-hot selected ALU: single-cycle logic/shift/add/sub/compare ops with one cycle of latency,
// plus a shift-add multiply of the low operand halves that runs for WIDTH/2 cycles.
module multicycle_arithmetic_unit #(
   parameter int WIDTH      = 16,
   parameter int SIGNED_CMP = 0
) (
   input  logic                          clk,
   input  logic                          ExternalReset,
   multicycle_arithmetic_unit_if.slave   bus
);
   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(H) + 1;

   localparam logic [9:0] OP_B    = 10'b10_0000_0000;
   localparam logic [9:0] OP_AND  = 10'b01_0000_0000;
   localparam logic [9:0] OP_OR   = 10'b00_1000_0000;
   localparam logic [9:0] OP_NOT  = 10'b00_0100_0000;
   localparam logic [9:0] OP_SHL  = 10'b00_0010_0000;
   localparam logic [9:0] OP_SHR  = 10'b00_0001_0000;
   localparam logic [9:0] OP_ADD  = 10'b00_0000_1000;
   localparam logic [9:0] OP_SUB  = 10'b00_0000_0100;
   localparam logic [9:0] OP_MUL  = 10'b00_0000_0010;
   localparam logic [9:0] OP_CMP  = 10'b00_0000_0001;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             r_zout;
   logic             r_err;
   logic [WIDTH-1:0] r_aluout;
   logic [CW-1:0]    r_cnt;

   logic             r_vld_p0;
   logic [9:0]       r_op_p0;
   logic [WIDTH-1:0] r_a_p0;
   logic [WIDTH-1:0] r_b_p0;
   logic             r_cin_p0;

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc;
   logic [H-1:0]     r_mplier;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_last;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_gt;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_z;
   logic             w_err;
   logic [WIDTH-1:0] w_acc_nxt;

   assign w_accept  = bus.start & ~r_busy;
   assign w_is_mul  = (bus.op == OP_MUL);
   assign w_last    = (r_cnt == CW'(H - 1));
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Stage p0 -> p1: single-cycle result computed from the operands latched at acceptance
   assign w_sum  = {1'b0, r_a_p0} + {1'b0, r_b_p0} + {{WIDTH{1'b0}}, r_cin_p0};
   assign w_diff = {1'b0, r_a_p0} - {1'b0, r_b_p0} - {{WIDTH{1'b0}}, r_cin_p0};

   always_comb begin
      if (SIGNED_CMP != 0) w_gt = ($signed(r_a_p0) > $signed(r_b_p0));
      else                 w_gt = (r_a_p0 > r_b_p0);
   end

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_err = 1'b0;
      case (r_op_p0)
         OP_B:    w_res = r_b_p0;
         OP_AND:  w_res = r_a_p0 & r_b_p0;
         OP_OR:   w_res = r_a_p0 | r_b_p0;
         OP_NOT:  w_res = ~r_b_p0;
         OP_SHL:  begin w_res = {r_b_p0[WIDTH-2:0], 1'b0}; w_c = r_b_p0[WIDTH-1]; end
         OP_SHR:  begin w_res = {1'b0, r_b_p0[WIDTH-1:1]}; w_c = r_b_p0[0];       end
         OP_ADD:  begin w_res = w_sum[WIDTH-1:0];          w_c = w_sum[WIDTH];    end
         OP_SUB:  begin w_res = w_diff[WIDTH-1:0];         w_c = w_diff[WIDTH];   end
         OP_CMP:  begin w_res = r_a_p0;                    w_c = w_gt;            end
         default: w_err = 1'b1;
      endcase
      w_z = (r_op_p0 == OP_CMP) ? (r_a_p0 == r_b_p0) : (w_res == '0);
   end

   always_ff @(posedge clk) begin
      if (ExternalReset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_aluout <= '0;
         r_cout   <= 1'b0;
         r_zout   <= 1'b0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_vld_p0 <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_vld_p0 <= w_accept & ~w_is_mul;
         if (r_vld_p0) begin
            r_aluout <= w_res;
            r_cout   <= w_c;
            r_zout   <= w_z;
            r_err    <= w_err;
            r_done   <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state <= S_MUL;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_MUL: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_aluout <= w_acc_nxt;
                  r_cout   <= 1'b0;
                  r_zout   <= (w_acc_nxt == '0);
                  r_err    <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operand and multiplier datapath registers carry no reset; the control above gates their use
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op_p0  <= bus.op;
         r_a_p0   <= bus.A;
         r_b_p0   <= bus.B;
         r_cin_p0 <= bus.cin;
      end
      if (w_accept && w_is_mul) begin
         r_mcand  <= {{(WIDTH-H){1'b0}}, bus.A[H-1:0]};
         r_mplier <= bus.B[H-1:0];
         r_acc    <= '0;
      end else if (r_state == S_MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

   assign bus.aluout = r_aluout;
   assign bus.cout   = r_cout;
   assign bus.zout   = r_zout;
   assign bus.done   = r_done;
   assign bus.busy   = r_busy;
   assign bus.err    = r_err;
endmodule
